// File: rtl/priority_encoder_if.sv
// Request/result bundle for the registered priority encoder.
// The requester side (master) drives the enable and request vector.
// The encoder side (slave) returns the registered index and valid flag.
// When PRIENC_ONEHOT_EN is defined the bundle also carries a one-hot grant mask.
interface priority_encoder_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
);
    logic             en;
    logic [WIDTH-1:0] i;
    logic [OUT_W-1:0] y;
    logic             valid;
`ifdef PRIENC_ONEHOT_EN
    logic [WIDTH-1:0] grant;

    modport master (output en, output i, input y, input valid, input grant);
    modport slave  (input en, input i, output y, output valid, output grant);
`else
    modport master (output en, output i, input y, input valid);
    modport slave  (input en, input i, output y, output valid);
`endif
endinterface

// File: rtl/priority_encoder.sv
// Registered WIDTH-to-OUT_W priority encoder with enable.
// Reports the index of the highest-numbered set request bit one cycle after
// it is sampled, together with a valid flag that separates "bit 0 won" from
// "nothing requested". Asynchronous active-low reset clears all outputs.
// Optional macro PRIENC_ONEHOT_EN adds a registered one-hot grant mask that
// marks the winning bit with the same timing as y.
// WIDTH must be a power of two (>= 2) and OUT_W must equal log2(WIDTH).
module priority_encoder #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    priority_encoder_if.slave  bus
);

    logic [OUT_W-1:0] w_index;
    logic             w_any;
    logic             w_valid;
    logic [OUT_W-1:0] w_y;

    logic [OUT_W-1:0] r_y;
    logic             r_valid;

    // Scan the request vector from the top bit down; the first set bit found wins.
    always_comb begin
        w_index = '0;
        w_any   = 1'b0;
        for (int n = WIDTH - 1; n >= 0; n--) begin
            if (!w_any && bus.i[n]) begin
                w_index = OUT_W'(n);
                w_any   = 1'b1;
            end
        end
    end

    // A result is only real when encoding is enabled and some request is present.
    always_comb begin
        w_valid = bus.en && w_any;
        w_y     = w_valid ? w_index : '0;
    end

    // Single register stage; every edge re-evaluates the current inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_y;
            r_valid <= w_valid;
        end
    end

    assign bus.y     = r_y;
    assign bus.valid = r_valid;

`ifdef PRIENC_ONEHOT_EN
    logic [WIDTH-1:0] w_grant;
    logic [WIDTH-1:0] r_grant;

    // Build the one-hot mask of the winning bit; all zeros when nothing wins.
    always_comb begin
        w_grant = '0;
        if (w_valid) begin
            w_grant[w_index] = 1'b1;
        end
    end

    // Grant is registered alongside y so both change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
        end else begin
            r_grant <= w_grant;
        end
    end

    assign bus.grant = r_grant;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard testbench for priority_encoder.
// Stimulus pushes the expected response from a behavioural model into a queue;
// a monitor process pops and compares after every clock edge that consumed it.
// Grant checks are included when PRIENC_ONEHOT_EN is defined.
module tb_priority_encoder;

    localparam int WIDTH = 8;
    localparam int OUT_W = 3;

    typedef struct {
        logic [OUT_W-1:0] y;
        logic             valid;
        logic [WIDTH-1:0] grant;
    } expT;

    logic clk;
    logic rst_n;
    int   vectorCount;
    int   miscompares;
    expT  expQ[$];

    priority_encoder_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();

    priority_encoder #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the winner is floor(log2(v)) for any nonzero request when enabled.
    function automatic expT refModel(input logic e, input logic [WIDTH-1:0] v);
        expT         r;
        int unsigned val;
        int unsigned idx;
        r.y     = '0;
        r.valid = 1'b0;
        r.grant = '0;
        val     = int'(v);
        if (e && val != 0) begin
            idx     = $clog2(val + 1) - 1;
            r.y     = idx[OUT_W-1:0];
            r.valid = 1'b1;
            r.grant = WIDTH'(1) << idx;
        end
        return r;
    endfunction

    // Compare the DUT outputs against an expected response and count the result.
    task automatic checkOutput(input string name, input logic [OUT_W-1:0] expY,
                               input logic expValid, input logic [WIDTH-1:0] expGrant);
        logic ok;
        vectorCount++;
        ok = (bus.y === expY) && (bus.valid === expValid);
`ifdef PRIENC_ONEHOT_EN
        ok = ok && (bus.grant === expGrant);
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s: got y=%0d valid=%b grant=%b, expected y=%0d valid=%b grant=%b",
                     name, bus.y, bus.valid, bus.grant, expY, expValid, expGrant);
        end
`else
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s: got y=%0d valid=%b, expected y=%0d valid=%b (grant %b)",
                     name, bus.y, bus.valid, expY, expValid, expGrant);
        end
`endif
    endtask

    // Drive one vector at a falling edge, record what it must produce, advance a cycle.
    task automatic applyStimulus(input logic e, input logic [WIDTH-1:0] v);
        bus.en = e;
        bus.i  = v;
        expQ.push_back(refModel(e, v));
        @(negedge clk);
    endtask

    // Monitor: after each rising edge, retire one expected response if pending.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("scoreboard", e.y, e.valid, e.grant);
            end
        end
    end

    // Watchdog so the run always ends with a summary line.
    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

    // Main stimulus sequence.
    initial begin
        logic [WIDTH-1:0] mixed[5];
        logic [WIDTH-1:0] bounds[4];
        logic [WIDTH-1:0] v;
        logic             e;
        int unsigned      mode;

        mixed  = '{8'b00100101, 8'b00001100, 8'b01000010, 8'b00110000, 8'b00001001};
        bounds = '{8'b00000001, 8'b00000000, 8'b10000000, 8'hFF};

        vectorCount = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.i   = '0;

        // Reset clears outputs before any clock edge and holds them while low.
        #3;
        checkOutput("resetAsync", 3'd0, 1'b0, 8'h00);
        bus.en = 1'b1;
        bus.i  = 8'hFF;
        @(posedge clk);
        #1;
        checkOutput("resetHold", 3'd0, 1'b0, 8'h00);

        // Release reset, then two disabled edges with a live request.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'b00100101);
        applyStimulus(1'b0, 8'b00100101);

        // Directed mixed vectors and boundary cases.
        foreach (mixed[k])  applyStimulus(1'b1, mixed[k]);
        foreach (bounds[k]) applyStimulus(1'b1, bounds[k]);

        // Enable drop after a valid result.
        applyStimulus(1'b1, 8'h42);
        applyStimulus(1'b0, 8'h42);

        // Asynchronous reset pulse between edges while y=6, valid=1.
        applyStimulus(1'b1, 8'h42);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetMid", 3'd0, 1'b0, 8'h00);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 8'b10000001);
        applyStimulus(1'b1, 8'b00110000);
        applyStimulus(1'b1, 8'h00);

        // Randomized traffic biased toward the interesting corners.
        for (int n = 0; n < 300; n++) begin
            e    = ($urandom_range(0, 7) != 0);
            mode = $urandom_range(0, 3);
            case (mode)
                0:       v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                1:       v = '0;
                default: v = WIDTH'($urandom);
            endcase
            applyStimulus(e, v);
        end

        // Let the monitor drain everything that was issued.
        repeat (3) @(posedge clk);
        #2;
        vectorCount++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d responses pending, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule

// File: doc/priority_encoder.md
Name: priority_encoder

Overview:
- Registered 8-to-3 priority encoder with enable.
- Reports the index of the highest-numbered asserted input bit, plus a valid flag.
- Used wherever a request vector must be reduced to a single binary index, such as interrupt or request arbitration front-ends.
- Output is registered: one-cycle latency, glitch-free.

Parameters:
- WIDTH, 8, number of request inputs; must be a power of two, at least 2.
- OUT_W, 3, index width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  encode enable; sampled on the rising edge of clk.
- i  input  WIDTH  request vector; bit WIDTH-1 has the highest priority.
- y  output  OUT_W  registered index of the highest set bit of i.
- valid  output  1  registered; high when y holds a real encode result.

Behaviour:
- Reset:
  - rst_n low asynchronously forces y=0 and valid=0, independent of clk.
  - Outputs hold these values while rst_n stays low.
  - Deassertion is taken synchronously: the first encode happens on the first rising clk edge after rst_n goes high.
- Priority: MSB wins. y = the largest n for which i[n]=1. All lower bits are ignored.
- Latency: exactly 1 cycle. Values of en and i sampled at edge k appear on y/valid right after edge k.
- Inputs are not stored beyond one cycle. Each edge re-evaluates the current en and i.
- en=0 at an edge: y<=0 and valid<=0, whatever the value of i.
- en=1 with i=0: y<=0 and valid<=0. No request present.
- en=1 with i[0] as the only set bit: y<=0 and valid<=1. valid tells this case apart from the no-request case.
- en=1 with i=all ones: y<=WIDTH-1 and valid<=1.
- Reset asserted mid-operation: outputs clear immediately. No encode result survives reset.
- X or Z on i while en=1 is not supported. The bench must drive known values.
- Encode logic:
  - A purely combinational priority scan from MSB down to LSB feeds a single register stage.
  - There are no latches.
  - There is no other state.

Optional Feature:
- Macro: PRIENC_ONEHOT_EN.
- Defined:
  - Adds an output port grant, WIDTH bits wide, registered.
  - grant carries a one-hot mask of the winning bit (grant[y]=1) when valid=1, and is all zeros otherwise.
  - grant resets to 0 and has the same timing as y.
- Undefined: the grant port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset and disable: rst_n=0, then rst_n=1 with en=0 and i=8'b00100101, over 2 edges -> y=0, valid=0 throughout.
- Mixed vectors, en=1, one per cycle:
  - i=8'b00100101 -> y=5.
  - i=8'b00001100 -> y=3.
  - i=8'b01000010 -> y=6.
  - i=8'b00110000 -> y=5.
  - i=8'b00001001 -> y=3.
  - All with valid=1, each appearing one cycle after the vector is applied.
- Boundaries, en=1:
  - i=8'b00000001 -> y=0, valid=1.
  - i=8'b00000000 -> y=0, valid=0.
  - i=8'b10000000 -> y=7, valid=1.
  - i=8'hFF -> y=7, valid=1.
- Enable drop: en=1 with i=8'h42 (y=6, valid=1), then en=0 -> next edge y=0, valid=0.
- Async reset mid-stream: with y=6 and valid=1, pulse rst_n low between clock edges -> y=0 and valid=0 immediately, before the next edge. Encoding resumes on the first edge after release.
- With PRIENC_ONEHOT_EN defined: i=8'b00110000 -> grant=8'b00100000. i=0 -> grant=0.
